// File: rtl/mem_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the single-port synchronous memory.
// The arbiter connects through the slave modport; requesters and memory use the master side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a memory with 1-cycle synchronous read latency.
// One transaction in flight at a time: IDLE (grant) -> ISSUE (memory access) -> RWAIT (reads only).
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              grant0;
    logic              grant1;

    // Under contention the requester not granted last wins; last_q==1 favours requester 0.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && state_q == IDLE) begin
            if (bus.req0 && (!bus.req1 || last_q)) begin
                grant0 = 1'b1;
            end else if (bus.req1) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 2'b00;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d = ISSUE;
                    last_d  = grant1;
                    id_d    = grant1;
                    we_d    = grant1 ? bus.we1    : bus.we0;
                    addr_d  = grant1 ? bus.addr1  : bus.addr0;
                    wdata_d = grant1 ? bus.wdata1 : bus.wdata0;
                end
            end
            ISSUE: begin
                state_d = we_q ? IDLE : RWAIT;
            end
            RWAIT: begin
                rdata_d  = bus.mem_rdata;
                rvalid_d = id_q ? 2'b10 : 2'b01;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Memory strobes come straight from registers so the memory sees glitch-free inputs.
    assign bus.gnt0      = grant0;
    assign bus.gnt1      = grant1;
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.rvalid0   = rvalid_q[0];
    assign bus.rvalid1   = rvalid_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-requester traffic
// checked against a transaction-level model (arbitration rule, fixed latencies, reference memory).
module tb_mem_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [DW-1:0] ram [16] = '{default: '0};

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set0(1'b1, 1'b1, 4'd9, 8'h11);
        set1(1'b1, 1'b0, 4'd9, 8'h22);
        @(negedge clk); #1;
        n_total++; if ({bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.rvalid0, bus.rvalid1} !== 6'b0) begin n_bad++; $display("FAIL rst_ctrl: got=%b want=000000", {bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.rvalid0, bus.rvalid1}); end
        n_total++; if (bus.mem_addr !== 4'd0) begin n_bad++; $display("FAIL rst_addr: got=%h want=0", bus.mem_addr); end
        n_total++; if (bus.mem_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_wdata: got=%h want=00", bus.mem_wdata); end
        n_total++; if (bus.rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got=%h want=00", bus.rdata); end
        set0(1'b0, 1'b0, 4'd0, 8'h00);
        set1(1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        $display("txn reset: released");
    endtask

    // Entered on the reset-release negedge, so the grant is taken on the first rising edge.
    task automatic test_single_write();
        set0(1'b1, 1'b1, 4'd3, 8'hA5);
        #1;
        n_total++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_bad++; $display("FAIL sw_gnt: got=%b want=10", {bus.gnt0, bus.gnt1}); end
        @(negedge clk);
        set0(1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        n_total++; if ({bus.gnt0, bus.mem_en, bus.mem_we} !== 3'b011) begin n_bad++; $display("FAIL sw_issue: got=%b want=011", {bus.gnt0, bus.mem_en, bus.mem_we}); end
        n_total++; if ({bus.mem_addr, bus.mem_wdata} !== {4'd3, 8'hA5}) begin n_bad++; $display("FAIL sw_bus: got=%h/%h want=3/a5", bus.mem_addr, bus.mem_wdata); end
        @(negedge clk); #1;
        n_total++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL sw_idle: got=%b want=0", bus.mem_en); end
        $display("txn single_write: req0 wr addr=3 data=a5");
    endtask

    task automatic test_read_back();
        @(negedge clk);
        set1(1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        n_total++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin n_bad++; $display("FAIL rb_gnt: got=%b want=01", {bus.gnt0, bus.gnt1}); end
        @(negedge clk);
        set1(1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        n_total++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 4'd3}) begin n_bad++; $display("FAIL rb_issue: got=%b%b/%h want=10/3", bus.mem_en, bus.mem_we, bus.mem_addr); end
        @(negedge clk); #1;
        n_total++; if ({bus.mem_en, bus.rvalid0, bus.rvalid1} !== 3'b000) begin n_bad++; $display("FAIL rb_wait: got=%b want=000", {bus.mem_en, bus.rvalid0, bus.rvalid1}); end
        @(negedge clk); #1;
        n_total++; if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {2'b01, 8'hA5}) begin n_bad++; $display("FAIL rb_data: got=%b%b/%h want=01/a5", bus.rvalid0, bus.rvalid1, bus.rdata); end
        @(negedge clk); #1;
        n_total++; if ({bus.rvalid1, bus.rdata} !== {1'b0, 8'hA5}) begin n_bad++; $display("FAIL rb_hold: got=%b/%h want=0/a5", bus.rvalid1, bus.rdata); end
        $display("txn read_back: req1 rd addr=3 data=%02h", bus.rdata);
    endtask

    task automatic test_contention();
        bit eg0, eg1, ev0, ev1;
        @(negedge clk);
        rst = 1'b0;
        set0(1'b1, 1'b0, 4'd3, 8'h00);
        set1(1'b1, 1'b0, 4'd3, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            eg0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
            eg1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
            ev0 = (c >= 3) && (c % 3 == 0) && (((c / 3) - 1) % 2 == 0);
            ev1 = (c >= 3) && (c % 3 == 0) && (((c / 3) - 1) % 2 == 1);
            n_total++; if ({bus.gnt0, bus.gnt1} !== {eg0, eg1}) begin n_bad++; $display("FAIL ct_gnt c%0d: got=%b want=%b", c, {bus.gnt0, bus.gnt1}, {eg0, eg1}); end
            n_total++; if ({bus.rvalid0, bus.rvalid1} !== {ev0, ev1}) begin n_bad++; $display("FAIL ct_rvalid c%0d: got=%b want=%b", c, {bus.rvalid0, bus.rvalid1}, {ev0, ev1}); end
            if (ev0 || ev1) begin
                n_total++; if (bus.rdata !== 8'hA5) begin n_bad++; $display("FAIL ct_rdata c%0d: got=%h want=a5", c, bus.rdata); end
            end
            if (eg0 || eg1) $display("txn contention: cycle %0d grant req%0d", c, eg1 ? 1 : 0);
        end
        @(negedge clk);
        set0(1'b0, 1'b0, 4'd0, 8'h00);
        set1(1'b0, 1'b0, 4'd0, 8'h00);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_late_arrival();
        @(negedge clk);
        set0(1'b1, 1'b1, 4'd7, 8'h3C);
        #1;
        n_total++; if (bus.gnt0 !== 1'b1) begin n_bad++; $display("FAIL la_gnt0: got=%b want=1", bus.gnt0); end
        @(negedge clk);
        set0(1'b0, 1'b0, 4'd0, 8'h00);
        set1(1'b1, 1'b0, 4'd7, 8'h00);
        #1;
        n_total++; if ({bus.gnt1, bus.mem_en, bus.mem_we} !== 3'b011) begin n_bad++; $display("FAIL la_busy: got=%b want=011", {bus.gnt1, bus.mem_en, bus.mem_we}); end
        @(negedge clk); #1;
        n_total++; if (bus.gnt1 !== 1'b1) begin n_bad++; $display("FAIL la_gnt1: got=%b want=1", bus.gnt1); end
        @(negedge clk);
        set1(1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        n_total++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 4'd7}) begin n_bad++; $display("FAIL la_issue: got=%b%b/%h want=10/7", bus.mem_en, bus.mem_we, bus.mem_addr); end
        repeat (2) @(negedge clk);
        #1;
        n_total++; if ({bus.rvalid1, bus.rdata} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL la_data: got=%b/%h want=1/3c", bus.rvalid1, bus.rdata); end
        $display("txn late_arrival: req0 wr 7=3c then req1 rd data=%02h", bus.rdata);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        set1(1'b1, 1'b1, 4'd5, 8'h77);
        #1;
        n_total++; if (bus.gnt1 !== 1'b1) begin n_bad++; $display("FAIL rm_wgnt: got=%b want=1", bus.gnt1); end
        @(negedge clk);
        set1(1'b0, 1'b0, 4'd0, 8'h00);
        set0(1'b1, 1'b0, 4'd5, 8'h00);
        @(negedge clk); #1;
        n_total++; if (bus.gnt0 !== 1'b1) begin n_bad++; $display("FAIL rm_rgnt: got=%b want=1", bus.gnt0); end
        @(negedge clk);
        set0(1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        set1(1'b1, 1'b1, 4'd2, 8'h55);
        #1;
        n_total++; if ({bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.rvalid0, bus.rvalid1} !== 6'b0) begin n_bad++; $display("FAIL rm_ctrl: got=%b want=000000", {bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.rvalid0, bus.rvalid1}); end
        n_total++; if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 20'h0) begin n_bad++; $display("FAIL rm_data: got=%h/%h/%h want=0/00/00", bus.mem_addr, bus.mem_wdata, bus.rdata); end
        @(negedge clk);
        set1(1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_total++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin n_bad++; $display("FAIL rm_norv k%0d: got=%b want=00", k, {bus.rvalid0, bus.rvalid1}); end
        end
        @(negedge clk);
        set0(1'b1, 1'b0, 4'd5, 8'h00);
        #1;
        n_total++; if (bus.gnt0 !== 1'b1) begin n_bad++; $display("FAIL rm_regnt: got=%b want=1", bus.gnt0); end
        @(negedge clk);
        set0(1'b0, 1'b0, 4'd0, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        n_total++; if ({bus.rvalid0, bus.rdata} !== {1'b1, 8'h77}) begin n_bad++; $display("FAIL rm_reread: got=%b/%h want=1/77", bus.rvalid0, bus.rdata); end
        $display("txn reset_mid_read: aborted read, reread addr=5 data=%02h", bus.rdata);
    endtask

    task automatic test_mixed_stream();
        logic [DW-1:0] sb [16];
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            sb[a] = 8'(a) ^ 8'h5A;
            set0(1'b1, 1'b1, 4'(a), sb[a]);
            #1;
            n_total++; if (bus.gnt0 !== 1'b1) begin n_bad++; $display("FAIL ms_wgnt a%0d: got=%b want=1", a, bus.gnt0); end
            @(negedge clk);
            set0(1'b0, 1'b0, 4'd0, 8'h00);
            set1(1'b1, 1'b0, 4'(a), 8'h00);
            #1;
            n_total++; if ({bus.gnt1, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b01, 4'(a), sb[a]}) begin n_bad++; $display("FAIL ms_wr a%0d: got=%b%b/%h/%h want=01/%h/%h", a, bus.gnt1, bus.mem_we, bus.mem_addr, bus.mem_wdata, 4'(a), sb[a]); end
            @(negedge clk); #1;
            n_total++; if (bus.gnt1 !== 1'b1) begin n_bad++; $display("FAIL ms_rgnt a%0d: got=%b want=1", a, bus.gnt1); end
            @(negedge clk);
            set1(1'b0, 1'b0, 4'd0, 8'h00);
            repeat (2) @(negedge clk);
            #1;
            n_total++; if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {2'b01, sb[a]}) begin n_bad++; $display("FAIL ms_rd a%0d: got=%b%b/%h want=01/%h", a, bus.rvalid0, bus.rvalid1, bus.rdata, sb[a]); end
            $display("txn mixed: addr=%0d wr=%02h rd=%02h", a, sb[a], bus.rdata);
        end
    endtask

    // Model: one transaction at a time, writes occupy 2 cycles and reads 3; data comes from ref_mem.
    task automatic test_random(input int ncyc);
        bit            pend [2]   = '{1'b0, 1'b0};
        bit            p_we [2]   = '{1'b0, 1'b0};
        logic [AW-1:0] p_addr [2] = '{4'd0, 4'd0};
        logic [DW-1:0] p_wd [2]   = '{8'd0, 8'd0};
        logic [DW-1:0] ref_mem [16];
        bit            known [16];
        bit            last = 1'b1, t_we = 1'b0, rv_known = 1'b0, rd_known = 1'b1;
        int            free_at = 0, iss_at = -1, rv_at = -1, rv_id = 0, win, n_txn = 0;
        logic [AW-1:0] t_addr = '0;
        logic [DW-1:0] t_wd = '0, rv_data = '0, exp_rdata = '0;
        foreach (known[i]) known[i] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 99) < 45) begin
                    pend[r]   = 1'b1;
                    p_we[r]   = 1'($urandom_range(0, 1));
                    p_addr[r] = 4'($urandom_range(0, 15));
                    p_wd[r]   = 8'($urandom_range(0, 255));
                end
            end
            set0(pend[0], p_we[0], p_addr[0], p_wd[0]);
            set1(pend[1], p_we[1], p_addr[1], p_wd[1]);
            #1;
            win = -1;
            if (c >= free_at) begin
                if (pend[0] && pend[1]) win = last ? 0 : 1;
                else if (pend[0])       win = 0;
                else if (pend[1])       win = 1;
            end
            n_total++; if ({bus.gnt0, bus.gnt1} !== {win == 0, win == 1}) begin n_bad++; $display("FAIL rnd_gnt c%0d: got=%b want=%b", c, {bus.gnt0, bus.gnt1}, {win == 0, win == 1}); end
            n_total++; if (bus.mem_en !== (c == iss_at)) begin n_bad++; $display("FAIL rnd_en c%0d: got=%b want=%b", c, bus.mem_en, c == iss_at); end
            if (c == iss_at) begin
                n_total++; if ({bus.mem_we, bus.mem_addr} !== {t_we, t_addr}) begin n_bad++; $display("FAIL rnd_acc c%0d: got=%b/%h want=%b/%h", c, bus.mem_we, bus.mem_addr, t_we, t_addr); end
                if (t_we) begin
                    n_total++; if (bus.mem_wdata !== t_wd) begin n_bad++; $display("FAIL rnd_wd c%0d: got=%h want=%h", c, bus.mem_wdata, t_wd); end
                end
            end
            if (c == rv_at) begin
                exp_rdata = rv_data;
                rd_known  = rv_known;
            end
            n_total++; if ({bus.rvalid0, bus.rvalid1} !== {c == rv_at && rv_id == 0, c == rv_at && rv_id == 1}) begin n_bad++; $display("FAIL rnd_rv c%0d: got=%b want=%b", c, {bus.rvalid0, bus.rvalid1}, {c == rv_at && rv_id == 0, c == rv_at && rv_id == 1}); end
            if (rd_known) begin
                n_total++; if (bus.rdata !== exp_rdata) begin n_bad++; $display("FAIL rnd_rdata c%0d: got=%h want=%h", c, bus.rdata, exp_rdata); end
            end
            if (win >= 0) begin
                last    = (win == 1);
                t_we    = p_we[win];
                t_addr  = p_addr[win];
                t_wd    = p_wd[win];
                iss_at  = c + 1;
                free_at = c + (t_we ? 2 : 3);
                if (t_we) begin
                    ref_mem[t_addr] = t_wd;
                    known[t_addr]   = 1'b1;
                end else begin
                    rv_at    = c + 3;
                    rv_id    = win;
                    rv_data  = ref_mem[t_addr];
                    rv_known = known[t_addr];
                end
                pend[win] = 1'b0;
                n_txn++;
                $display("txn rand %0d: cycle %0d req%0d %s addr=%0d data=%02h", n_txn, c, win, t_we ? "wr" : "rd", t_addr, t_we ? t_wd : rv_data);
            end
        end
        @(negedge clk);
        set0(1'b0, 1'b0, 4'd0, 8'h00);
        set1(1'b0, 1'b0, 4'd0, 8'h00);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        set0(1'b0, 1'b0, 4'd0, 8'h00);
        set1(1'b0, 1'b0, 4'd0, 8'h00);
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_late_arrival();
        test_reset_mid_read();
        test_mixed_stream();
        test_random(400);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports req0/req1, input, 1 each, requester i transaction request.
REQ-006 The block SHALL have ports we0/we1, input, 1 each, 1=write, 0=read.
REQ-007 The block SHALL have ports addr0/addr1, input, ADDR_W each, and wdata0/wdata1, input, DATA_W each, request address and write data.
REQ-008 The block SHALL have ports gnt0/gnt1, output, 1 each, combinational request-accept strobe.
REQ-009 The block SHALL have ports rvalid0/rvalid1, output, 1 each, and rdata, output, DATA_W, shared read return data.
REQ-010 The block SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W); the memory has 1-cycle synchronous read latency.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE and RWAIT.
REQ-012 In IDLE, gnt_i SHALL be high only for the arbitration winner; it SHALL be low in ISSUE/RWAIT and never high for both requesters.
REQ-013 Arbitration SHALL be: one requester -> it wins; both -> the requester not granted last wins; a 1-bit last pointer updates on every accepted grant.
REQ-014 On a clock edge with gnt_i high, the block SHALL latch we_i/addr_i/wdata_i and the winner id, go to ISSUE; the requester may change or drop its signals after that edge.
REQ-015 Requesters SHALL hold req/we/addr/wdata stable until the edge where gnt is high; the block never drops a held request.
REQ-016 In ISSUE, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL equal the latched values, all decoded from registers only; mem_en=0 in every other state.
REQ-017 ISSUE SHALL go to IDLE for a write and to RWAIT for a read.
REQ-018 In RWAIT, the block SHALL register mem_rdata into rdata and go to IDLE; rvalid of the latched winner SHALL be high for exactly the next cycle.
REQ-019 rdata SHALL hold its last value until the next read return; rvalid0 and rvalid1 are never high together.
REQ-020 Latency: write reaches memory 1 cycle after the grant edge; read data is presented with rvalid 3 cycles after the grant edge; a new grant may coincide with the rvalid cycle.
REQ-021 Throughput: back-to-back writes SHALL be accepted every 2 cycles, reads every 3 cycles.
REQ-022 A request arriving while the FSM is not in IDLE SHALL wait, without loss, until IDLE.

Reset
REQ-023 While rst=0: state=IDLE, gnt0/gnt1=0 (gated by rst), rvalid0/rvalid1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, last pointer=1 (requester 0 wins first contention).
REQ-024 Reset asserted mid-transaction SHALL abort it immediately; an in-flight read SHALL produce no rvalid after reset releases.
REQ-025 After rst deasserts, the first grant SHALL be possible on the first rising edge.

Verification
REQ-026 Single write: req0=1, we0=1, addr0=3, wdata0=8'hA5 -> gnt0 for 1 cycle; next cycle mem_en=1, mem_we=1, mem_addr=3, mem_wdata=8'hA5; then IDLE.
REQ-027 Read-back: after REQ-026, req1=1, we1=0, addr1=3 -> mem_en=1, mem_we=0, mem_addr=3; rdata=8'hA5 with rvalid1=1 for one cycle, 3 cycles after grant, rvalid0=0.
REQ-028 Contention: req0 and req1 held high from reset release, both reads -> grant order 0,1,0,1; exactly one gnt per IDLE cycle; four rvalids alternate 0,1,0,1.
REQ-029 Late arrival: req1 raised during req0 ISSUE -> gnt1 in the first IDLE cycle after; req1 not lost.
REQ-030 Reset mid-read: assert rst in RWAIT of a read to addr 5 -> all outputs 0 immediately; no rvalid after release; next request to addr 5 completes normally.
REQ-031 Mixed stream: alternate write addr 0..15 with data=addr^8'h5A from req0 and reads of the same addr from req1 -> every read returns the written value and the scoreboard sees no mismatch.
